// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the shared block data memory.
// Grants one whole block transfer at a time and returns the finished block to its requester.
module dmem_arbiter #(
   parameter int ADDR_WIDTH     = 28,
   parameter int DATA_WIDTH     = 128,
   parameter int FIXED_PRIORITY = 0,
   parameter int TIMEOUT        = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  p0_read,
   input  logic                  p0_write,
   input  logic [ADDR_WIDTH-1:0] p0_address,
   input  logic [DATA_WIDTH-1:0] p0_writedata,
   output logic [DATA_WIDTH-1:0] p0_readdata,
   output logic                  p0_busywait,
   input  logic                  p1_read,
   input  logic                  p1_write,
   input  logic [ADDR_WIDTH-1:0] p1_address,
   input  logic [DATA_WIDTH-1:0] p1_writedata,
   output logic [DATA_WIDTH-1:0] p1_readdata,
   output logic                  p1_busywait,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_writedata,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   input  logic                  mem_busywait,
   output logic                  mem_error
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state, state_next;
   logic                  grant;      // port owning the current transfer
   logic                  rr_ptr;     // port preferred on the next tie
   logic                  sel;
   logic                  req0, req1;
   logic                  timeout_hit;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] p0_rd_q, p1_rd_q;

   assign req0 = p0_read | p0_write;
   assign req1 = p1_read | p1_write;
   assign timeout_hit = (state == ACCESS) && mem_busywait && (cnt == CW'(TIMEOUT - 1));

   // Port choice for an IDLE grant; a lone requester always wins.
   always_comb begin
      sel = req1;
      if (req0 && req1)
         sel = (FIXED_PRIORITY != 0) ? 1'b0 : rr_ptr;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // NOTE: state_next gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req0 || req1) state_next = ACCESS;
         ACCESS:  if (!mem_busywait || timeout_hit) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      p0_busywait = req0 && !((state == RESP) && (grant == 1'b0));
      p1_busywait = req1 && !((state == RESP) && (grant == 1'b1));
      p0_readdata = ((state == RESP) && (grant == 1'b0) && req0) ? mem_readdata : p0_rd_q;
      p1_readdata = ((state == RESP) && (grant == 1'b1) && req1) ? mem_readdata : p1_rd_q;
   end

   // Memory-side registers, grant bookkeeping and returned-block capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant         <= 1'b0;
         rr_ptr        <= 1'b0;
         cnt           <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         mem_error     <= 1'b0;
         p0_rd_q       <= '0;
         p1_rd_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant         <= sel;
                  cnt           <= '0;
                  mem_address   <= sel ? p1_address : p0_address;
                  mem_writedata <= sel ? p1_writedata : p0_writedata;
                  mem_write     <= sel ? p1_write : p0_write;
                  mem_read      <= sel ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
               end
            end
            ACCESS: begin
               if (!mem_busywait || timeout_hit) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               if (timeout_hit)
                  mem_error <= 1'b1;
            end
            RESP: begin
               // A requester that gave up mid-transfer gets nothing back.
               if (grant == 1'b0 && req0) p0_rd_q <= mem_readdata;
               if (grant == 1'b1 && req1) p1_rd_q <= mem_readdata;
               rr_ptr <= ~grant;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and a fixed-priority instance,
// each backed by a 16-beat block memory model.
module tb_dmem_arbiter;

   localparam logic [127:0] BLOCK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] A5BLK = {16{8'hA5}};

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         hold_busy = 1'b0;
   int           n_checks = 0;
   int           n_fail = 0;

   logic         p0_read = 0, p0_write = 0, p1_read = 0, p1_write = 0;
   logic [27:0]  p0_address = '0, p1_address = '0;
   logic [127:0] p0_writedata = '0, p1_writedata = '0;
   logic [127:0] p0_readdata, p1_readdata;
   logic         p0_busywait, p1_busywait;
   logic         mem_read, mem_write, mem_busywait, mem_error;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata, mem_readdata;

   logic         f_p0_read = 0, f_p1_read = 0;
   logic [127:0] f_p0_readdata, f_p1_readdata;
   logic         f_p0_busywait, f_p1_busywait;
   logic         f_mem_read, f_mem_write, f_mem_busywait, f_mem_error;
   logic [27:0]  f_mem_address;
   logic [127:0] f_mem_writedata, f_mem_readdata;

   logic [127:0] mem_q [0:31];
   int           beat = 0;
   int           f_beat = 0;

   always #5 clock = ~clock;

   dmem_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT(64)) u_dut (
      .clock(clock), .reset(reset),
      .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
      .p0_writedata(p0_writedata), .p0_readdata(p0_readdata), .p0_busywait(p0_busywait),
      .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
      .p1_writedata(p1_writedata), .p1_readdata(p1_readdata), .p1_busywait(p1_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .mem_error(mem_error)
   );

   dmem_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT(64)) u_fix (
      .clock(clock), .reset(reset),
      .p0_read(f_p0_read), .p0_write(1'b0), .p0_address(28'h10),
      .p0_writedata(128'h0), .p0_readdata(f_p0_readdata), .p0_busywait(f_p0_busywait),
      .p1_read(f_p1_read), .p1_write(1'b0), .p1_address(28'h10),
      .p1_writedata(128'h0), .p1_readdata(f_p1_readdata), .p1_busywait(f_p1_busywait),
      .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_address(f_mem_address),
      .mem_writedata(f_mem_writedata), .mem_readdata(f_mem_readdata),
      .mem_busywait(f_mem_busywait), .mem_error(f_mem_error)
   );

   // Memory model: busy for 15 beats, ready on the 16th beat of an access.
   assign mem_busywait   = hold_busy || !((mem_read || mem_write) && beat == 15);
   assign f_mem_busywait = !((f_mem_read || f_mem_write) && f_beat == 15);
   assign mem_readdata   = mem_q[mem_address[4:0]];
   assign f_mem_readdata = mem_q[f_mem_address[4:0]];

   always @(posedge clock) begin
      if (reset)
         mem_q[16] <= BLOCK;
      else if (mem_write && !mem_busywait)
         mem_q[mem_address[4:0]] <= mem_writedata;
      beat   <= (mem_read || mem_write) ? beat + 1 : 0;
      f_beat <= (f_mem_read || f_mem_write) ? f_beat + 1 : 0;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst mem_read", mem_read, 0);
      check("rst mem_write", mem_write, 0);
      check("rst mem_error", mem_error, 0);
      check("rst mem_address", mem_address, 0);
      check("rst mem_writedata", mem_writedata, 0);
      check("rst p0_readdata", p0_readdata, 0);
      check("rst p1_readdata", p1_readdata, 0);

      // Single uncontended read of address 0x10
      next_cycle();
      p0_read = 1; p0_address = 28'h10;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clock);
         check($sformatf("rd c%0d mem_read", c), mem_read, (c >= 1 && c <= 16));
         check($sformatf("rd c%0d p0_busywait", c), p0_busywait, (c != 17));
         if (c == 5) check("rd mem_address", mem_address, 28'h10);
         if (c == 17) check("rd passthrough", p0_readdata, BLOCK);
         next_cycle();
      end
      p0_read = 0;
      @(negedge clock);
      check("rd hold p0_readdata", p0_readdata, BLOCK);
      check("rd idle p0_busywait", p0_busywait, 0);

      // Port 1 writes 0xA5 pattern to address 3, then reads it back
      next_cycle();
      p1_write = 1; p1_address = 28'h3; p1_writedata = A5BLK;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clock);
         check($sformatf("wr c%0d mem_read", c), mem_read, 0);
         check($sformatf("wr c%0d mem_write", c), mem_write, (c >= 1 && c <= 16));
         check($sformatf("wr c%0d p1_busywait", c), p1_busywait, (c != 17));
         if (c == 5) check("wr mem_writedata", mem_writedata, A5BLK);
         next_cycle();
      end
      p1_write = 0; p1_read = 1;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clock);
         check($sformatf("wrd c%0d p1_busywait", c), p1_busywait, (c != 17));
         if (c == 17) check("wrd passthrough", p1_readdata, A5BLK);
         next_cycle();
      end
      p1_read = 0;
      @(negedge clock);
      check("wrd hold p1_readdata", p1_readdata, A5BLK);
      check("wrd p0 untouched", p0_readdata, BLOCK);

      // Contention under round-robin, starting from a freshly reset pointer
      next_cycle();
      reset = 1;
      next_cycle();
      reset = 0;
      p0_read = 1; p0_address = 28'h10;
      p1_read = 1; p1_address = 28'h3;
      for (int c = 0; c <= 53; c++) begin
         @(negedge clock);
         check($sformatf("rr c%0d p0_busywait", c), p0_busywait, (c != 17 && c != 53));
         check($sformatf("rr c%0d p1_busywait", c), p1_busywait, (c != 35));
         if (c == 35) check("rr p1 data", p1_readdata, A5BLK);
         next_cycle();
      end
      p0_read = 0; p1_read = 0;
      @(negedge clock);
      check("rr p0 data", p0_readdata, BLOCK);

      // Fixed priority: port 1 starves while port 0 keeps requesting
      next_cycle();
      f_p0_read = 1; f_p1_read = 1;
      for (int c = 0; c <= 71; c++) begin
         @(negedge clock);
         check($sformatf("fix c%0d p0_busywait", c), f_p0_busywait,
               !(c == 17 || c == 35 || c == 53 || c == 71));
         check($sformatf("fix c%0d p1_busywait", c), f_p1_busywait, 1);
         next_cycle();
      end
      f_p0_read = 0; f_p1_read = 0;
      @(negedge clock);
      check("fix p0 data", f_p0_readdata, BLOCK);
      check("fix p1 data", f_p1_readdata, 0);

      // Timeout with the memory held busy
      next_cycle();
      hold_busy = 1;
      p0_read = 1; p0_address = 28'h10;
      for (int c = 0; c <= 65; c++) begin
         @(negedge clock);
         check($sformatf("to c%0d mem_read", c), mem_read, (c >= 1 && c <= 64));
         check($sformatf("to c%0d p0_busywait", c), p0_busywait, (c != 65));
         check($sformatf("to c%0d mem_error", c), mem_error, (c >= 65));
         next_cycle();
      end
      p0_read = 0; hold_busy = 0;
      @(negedge clock);
      check("to idle mem_read", mem_read, 0);
      check("to sticky mem_error", mem_error, 1);
      next_cycle();
      p0_read = 1;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clock);
         check($sformatf("to2 c%0d p0_busywait", c), p0_busywait, (c != 17));
         if (c == 17) begin
            check("to2 mem_error", mem_error, 1);
            check("to2 passthrough", p0_readdata, BLOCK);
         end
         next_cycle();
      end
      p0_read = 0;

      // Reset asserted in ACCESS cycle 8, then a normal transfer
      next_cycle();
      p0_read = 1;
      repeat (8) next_cycle();
      check("rs pre mem_read", mem_read, 1);
      reset = 1;
      #1;
      check("rs mem_read", mem_read, 0);
      check("rs mem_error", mem_error, 0);
      check("rs mem_address", mem_address, 0);
      check("rs p0_readdata", p0_readdata, 0);
      check("rs p0_busywait", p0_busywait, 1);
      next_cycle();
      next_cycle();
      reset = 0;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clock);
         check($sformatf("rs2 c%0d mem_read", c), mem_read, (c >= 1 && c <= 16));
         check($sformatf("rs2 c%0d p0_busywait", c), p0_busywait, (c != 17));
         next_cycle();
      end
      p0_read = 0;
      @(negedge clock);
      check("rs2 p0_readdata", p0_readdata, BLOCK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
